// File: rtl/cplx_mac_pkg.sv
// cplx_mac_pkg: shared types, helpers and field macros for the complex MAC.
// Build option: CPLX_MAC_SATURATE_EN selects clamping accumulation.
`ifndef CPLX_MAC_PKG_SV
`define CPLX_MAC_PKG_SV

`define CPLX_RE(v, w) v[2*(w)-1:(w)]
`define CPLX_IM(v, w) v[(w)-1:0]
`define CPLX_RE_S(v, w) $signed(`CPLX_RE(v, w))
`define CPLX_IM_S(v, w) $signed(`CPLX_IM(v, w))

package cplx_mac_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_RR = 3'd1,
    M_II = 3'd2,
    M_RI = 3'd3,
    M_IR = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int W_DEF     = 8;
  localparam int GUARD_DEF = 4;

  // Full product is 2W+1 bits; guard bits absorb accumulation growth.
  function automatic int acc_width(input int w, input int guard);
    return 2 * w + 1 + guard;
  endfunction

endpackage

`endif

// File: rtl/cplx_mac_seq_addsat.sv
// cplx_mac_seq_addsat: ACC_W add/subtract with optional clamp.
// Build option: CPLX_MAC_SATURATE_EN enables clamping and the clamp flag.
module cplx_mac_seq_addsat #(
  parameter int ACC_W = 21
) (
  input  logic signed [ACC_W-1:0] x,
  input  logic signed [ACC_W-1:0] y,
  input  logic                    sub,
  output logic signed [ACC_W-1:0] sum,
  output logic                    clamp
);

`ifdef CPLX_MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;
  logic           ovr;

  // One extra bit holds the true sign; disagreement means out of range.
  always_comb begin
    wide = sub ? ({x[ACC_W-1], x} - {y[ACC_W-1], y})
               : ({x[ACC_W-1], x} + {y[ACC_W-1], y});
    ovr  = wide[ACC_W] ^ wide[ACC_W-1];
    if (ovr)
      sum = wide[ACC_W] ? MINV : MAXV;
    else
      sum = wide[ACC_W-1:0];
    clamp = ovr;
  end
`else
  // Plain two's-complement wrap; never reports overflow.
  always_comb begin
    sum   = sub ? (x - y) : (x + y);
    clamp = 1'b0;
  end
`endif

endmodule

// File: rtl/cplx_mac_seq.sv
// cplx_mac_seq: sequential complex MAC, one shared real multiplier, 4 steps.
// Build option: CPLX_MAC_SATURATE_EN clamps each step and drives ovf.
module cplx_mac_seq
  import cplx_mac_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int GUARD = GUARD_DEF,
  localparam int ACC_W = acc_width(W, GUARD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*W-1:0]     a,
  input  logic [2*W-1:0]     b,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*ACC_W-1:0] out,
  output logic               ovf
);

  state_t state;

  logic signed [W-1:0]     ar;
  logic signed [W-1:0]     ai;
  logic signed [W-1:0]     br;
  logic signed [W-1:0]     bi;
  logic                    clr;
  logic signed [ACC_W-1:0] re_acc;
  logic signed [ACC_W-1:0] im_acc;
  logic                    ovf_r;

  logic signed [W-1:0]     mx;
  logic signed [W-1:0]     my;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] base;
  logic                    sub;
  logic signed [ACC_W-1:0] sum;
  logic                    clamp;

  // Pick multiplier operands and the running base for the current step.
  always_comb begin
    mx   = ar;
    my   = br;
    sub  = 1'b0;
    base = re_acc;
    unique case (state)
      M_RR: begin
        mx   = ar;
        my   = br;
        base = clr ? '0 : re_acc;
      end
      M_II: begin
        mx   = ai;
        my   = bi;
        sub  = 1'b1;
        base = re_acc;
      end
      M_RI: begin
        mx   = ar;
        my   = bi;
        base = clr ? '0 : im_acc;
      end
      M_IR: begin
        mx   = ai;
        my   = br;
        base = im_acc;
      end
      default: ;
    endcase
  end

  assign prod     = mx * my;
  assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

  cplx_mac_seq_addsat #(
    .ACC_W(ACC_W)
  ) u_addsat (
    .x    (base),
    .y    (prod_ext),
    .sub  (sub),
    .sum  (sum),
    .clamp(clamp)
  );

  // Control FSM plus operand, accumulator and sticky-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ar        <= '0;
      ai        <= '0;
      br        <= '0;
      bi        <= '0;
      clr       <= 1'b0;
      re_acc    <= '0;
      im_acc    <= '0;
      ovf_r     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ar       <= `CPLX_RE_S(a, W);
            ai       <= `CPLX_IM_S(a, W);
            br       <= `CPLX_RE_S(b, W);
            bi       <= `CPLX_IM_S(b, W);
            clr      <= acc_clr;
            if (acc_clr)
              ovf_r  <= 1'b0;
            in_ready <= 1'b0;
            state    <= M_RR;
          end
        end
        M_RR: begin
          re_acc <= sum;
          ovf_r  <= ovf_r | clamp;
          state  <= M_II;
        end
        M_II: begin
          re_acc <= sum;
          ovf_r  <= ovf_r | clamp;
          state  <= M_RI;
        end
        M_RI: begin
          im_acc <= sum;
          ovf_r  <= ovf_r | clamp;
          state  <= M_IR;
        end
        M_IR: begin
          im_acc    <= sum;
          ovf_r     <= ovf_r | clamp;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign out = {re_acc, im_acc};
  assign ovf = ovf_r;

endmodule

// File: tb/tb_cplx_mac_seq.sv
// tb_cplx_mac_seq: vector table, corner sequences and random ops vs a model.
// Honours CPLX_MAC_SATURATE_EN for expected overflow behaviour.
module tb_cplx_mac_seq;

  localparam int AW8 = 21;
  localparam int AW4 = 9;
  localparam int ACCEPT_GAP = 6;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, ovf;
  logic [15:0] a, b;
  logic [41:0] out8;

  logic        iv4, ir4, clr4, ov4, or4, ovf4;
  logic [7:0]  a4, b4;
  logic [17:0] out4;

  int nvec = 0;
  int nmis = 0;

  longint m_re = 0;
  longint m_im = 0;
  bit     m_ovf = 0;

  always #5 clk = ~clk;

  cplx_mac_seq #(.W(8), .GUARD(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out8), .ovf(ovf)
  );

  cplx_mac_seq #(.W(4), .GUARD(0)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .acc_clr(clr4),
    .out_valid(ov4), .out_ready(or4),
    .out(out4), .ovf(ovf4)
  );

  typedef struct {
    int ar, ai, br, bi;
    bit clr;
    int er, ei;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int re, input int im);
    logic [7:0] r;
    logic [7:0] i;
    r = 8'(re);
    i = 8'(im);
    return {r, i};
  endfunction

  // Bring a value into range: clamp or wrap depending on build.
  function automatic longint fit(input longint v, input int aw, inout bit o);
    longint hi, lo, m, r;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -(longint'(1) <<< (aw - 1));
`ifdef CPLX_MAC_SATURATE_EN
    if (v > hi) begin o = 1; return hi; end
    if (v < lo) begin o = 1; return lo; end
    return v;
`else
    m = longint'(1) <<< aw;
    r = v % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
    return r;
`endif
  endfunction

  // Complex MAC as step-wise arithmetic on integers.
  task automatic model_op(input logic [15:0] av, input logic [15:0] bv,
                          input bit c, output longint re, output longint im);
    longint xr, xi, yr, yi, bre, bim;
    xr = longint'($signed(av[15:8]));
    xi = longint'($signed(av[7:0]));
    yr = longint'($signed(bv[15:8]));
    yi = longint'($signed(bv[7:0]));
    if (c) m_ovf = 0;
    bre = c ? 0 : m_re;
    bim = c ? 0 : m_im;
    re = fit(fit(bre + xr * yr, AW8, m_ovf) - xi * yi, AW8, m_ovf);
    im = fit(fit(bim + xr * yi, AW8, m_ovf) + xi * yr, AW8, m_ovf);
    m_re = re;
    m_im = im;
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input bit c, input int stall, input bit poke,
                        output longint re, output longint im,
                        output int lat);
    int n;
    logic [41:0] held;
    a = av;
    b = bv;
    acc_clr = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    re = longint'($signed(out8[41:21]));
    im = longint'($signed(out8[20:0]));
    held = out8;
    if (stall > 0) begin
      out_ready = 1'b0;
      if (poke) begin
        in_valid = 1'b1;
        a = av ^ 16'h0101;
        acc_clr = 1'b1;
      end
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check("hold_out", out8, held);
        check("hold_in_ready", in_ready, 0);
        check("hold_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
  endtask

  task automatic run4(input logic [7:0] av, input logic [7:0] bv,
                      input bit c, output longint re, output longint im,
                      output bit o);
    int n;
    a4 = av;
    b4 = bv;
    clr4 = c;
    iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("u4_latency", n, 4);
    re = longint'($signed(out4[17:9]));
    im = longint'($signed(out4[8:0]));
    o = ovf4;
    @(posedge clk); #1;
  endtask

  initial begin
    longint re, im, ere, eim;
    int lat;
    bit o;
    logic [15:0] ra, rb;
    bit rc;
    int cyc, idx, got;
    int acc_t[3];
    logic [15:0] tp_a[3];
    logic [15:0] tp_b[3];
    longint tp_re[3];
    longint tp_im[3];
    bit acc_now;

    tbl[0] = '{-1, 4, 5, -3, 1, 7, 23};
    tbl[1] = '{7, 0, 2, -4, 1, 14, -28};
    tbl[2] = '{2, 1, 5, -4, 1, 14, -3};
    tbl[3] = '{4, 7, -12, -5, 1, -13, -104};
    tbl[4] = '{-1, 4, 5, -3, 1, 7, 23};
    tbl[5] = '{7, 0, 2, -4, 0, 21, -5};
    tbl[6] = '{2, 1, 5, -4, 0, 35, -8};
    tbl[7] = '{4, 7, -12, -5, 0, 22, -112};

    rst_n = 1'b0;
    in_valid = 1'b0;
    acc_clr = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    iv4 = 1'b0;
    clr4 = 1'b0;
    a4 = '0;
    b4 = '0;
    or4 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out8, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single products, then a four-term accumulation.
    for (int i = 0; i < 8; i++) begin
      ra = pk(tbl[i].ar, tbl[i].ai);
      rb = pk(tbl[i].br, tbl[i].bi);
      model_op(ra, rb, tbl[i].clr, ere, eim);
      run_op(ra, rb, tbl[i].clr, 0, 0, re, im, lat);
      check($sformatf("tbl%0d_latency", i), lat, 4);
      check($sformatf("tbl%0d_re", i), re, tbl[i].er);
      check($sformatf("tbl%0d_im", i), im, tbl[i].ei);
      check($sformatf("tbl%0d_model_re", i), re, ere);
      check($sformatf("tbl%0d_model_im", i), im, eim);
      check($sformatf("tbl%0d_ovf", i), ovf, 0);
    end

    // Back-pressure with a competing operand offered while stalled.
    ra = pk(3, -2);
    rb = pk(4, 5);
    model_op(ra, rb, 1'b1, ere, eim);
    run_op(ra, rb, 1'b1, 6, 1, re, im, lat);
    check("bp_re", re, 22);
    check("bp_im", im, 7);
    ra = pk(1, 1);
    rb = pk(1, 1);
    model_op(ra, rb, 1'b0, ere, eim);
    run_op(ra, rb, 1'b0, 0, 0, re, im, lat);
    check("bp_follow_re", re, 22);
    check("bp_follow_im", im, 9);

    // Reset while in M_RI aborts the operation.
    a = pk(9, 9);
    b = pk(9, 9);
    acc_clr = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out8, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_re = 0;
    m_im = 0;
    m_ovf = 0;
    ra = pk(3, -2);
    rb = pk(4, 5);
    model_op(ra, rb, 1'b0, ere, eim);
    run_op(ra, rb, 1'b0, 0, 0, re, im, lat);
    check("midrst_acc_re", re, 22);
    check("midrst_acc_im", im, 7);

    // Throughput with in_valid held high.
    tp_a[0] = pk(5, -6);   tp_b[0] = pk(-7, 8);
    tp_a[1] = pk(-128, 0); tp_b[1] = pk(-128, 0);
    tp_a[2] = pk(1, 2);    tp_b[2] = pk(3, 4);
    model_op(tp_a[0], tp_b[0], 1'b1, tp_re[0], tp_im[0]);
    model_op(tp_a[1], tp_b[1], 1'b0, tp_re[1], tp_im[1]);
    model_op(tp_a[2], tp_b[2], 1'b0, tp_re[2], tp_im[2]);
    cyc = 0;
    idx = 0;
    got = 0;
    a = tp_a[0];
    b = tp_b[0];
    acc_clr = 1'b1;
    in_valid = 1'b1;
    while (got < 3 && cyc < 80) begin
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("tp%0d_re", got),
              longint'($signed(out8[41:21])), tp_re[got]);
        check($sformatf("tp%0d_im", got),
              longint'($signed(out8[20:0])), tp_im[got]);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_t[idx] = cyc;
        idx++;
        if (idx < 3) begin
          a = tp_a[idx];
          b = tp_b[idx];
          acc_clr = 1'b0;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("tp_results", got, 3);
    check("tp_accepts", idx, 3);
    check("tp_gap01", acc_t[1] - acc_t[0], ACCEPT_GAP);
    check("tp_gap12", acc_t[2] - acc_t[1], ACCEPT_GAP);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random operands, clears and stalls.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = ($urandom_range(0, 3) == 0);
      model_op(ra, rb, rc, ere, eim);
      run_op(ra, rb, rc, $urandom_range(0, 2), 0, re, im, lat);
      check($sformatf("rnd%0d_latency", i), lat, 4);
      check($sformatf("rnd%0d_re", i), re, ere);
      check($sformatf("rnd%0d_im", i), im, eim);
      check($sformatf("rnd%0d_ovf", i), ovf, m_ovf);
    end

    // Narrow instance: accumulation overflow of the imaginary part.
    run4(8'h88, 8'h88, 1'b1, re, im, o);
    check("u4_first_re", re, 0);
    check("u4_first_im", im, 128);
    check("u4_first_ovf", o, 0);
    run4(8'h88, 8'h88, 1'b0, re, im, o);
    check("u4_acc_re", re, 0);
`ifdef CPLX_MAC_SATURATE_EN
    check("u4_acc_im", im, 255);
    check("u4_acc_ovf", o, 1);
`else
    check("u4_acc_im", im, -256);
    check("u4_acc_ovf", o, 0);
`endif
    run4(8'h10, 8'h10, 1'b1, re, im, o);
    check("u4_clr_re", re, 1);
    check("u4_clr_im", im, 0);
    check("u4_clr_ovf", o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
